// File: rtl/rambam_pkg.sv
// Shared types and constants for the RAMBAM encode feed.
// The carry-less multiply helper is used by the RTL encoder and by the bench model.
package rambam_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        READY = 1'b1
    } feed_state_t;

    // Redundancy degree this parameter set is built around; the helper below is sized for it
    localparam int          RAMBAM_D          = 4;
    localparam logic [8:0]  DEFAULT_P         = 9'h11B;
    localparam logic [31:0] DEFAULT_LFSR_TAPS = 32'h80200003;
    localparam logic [31:0] DEFAULT_LFSR_SEED = 32'hACE1_2468;

    // Carry-less product P(x)*rho(x); degree stays below 8+D, so no reduction is needed
    function automatic logic [7+RAMBAM_D:0] clmul_p(input logic [8:0]          p,
                                                     input logic [RAMBAM_D-1:0] rho);
        logic [7+RAMBAM_D:0] acc;
        acc = '0;
        for (int k = 0; k < RAMBAM_D; k++) begin
            if (rho[k]) begin
                acc = acc ^ ({{(RAMBAM_D-1){1'b0}}, p} << k);
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/rambam_lfsr_pool.sv
// Randomness source: 32-bit Fibonacci LFSR serialised into an 8*D-bit pool.
// Runs only while 'run' is high; pool_full flags the last cycle of a fill.
module rambam_lfsr_pool
    import rambam_pkg::*;
#(
    parameter int          D         = RAMBAM_D,
    parameter logic [31:0] LFSR_TAPS = DEFAULT_LFSR_TAPS,
    parameter logic [31:0] LFSR_SEED = DEFAULT_LFSR_SEED
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           run,
    output logic [8*D-1:0] pool,
    output logic           pool_full
);

    // An all-zero seed would lock the LFSR, so it is replaced by 1
    localparam logic [31:0] SEED_EFF = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
    localparam int          CNT_W    = $clog2(8*D);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(8*D-1);

    logic [31:0]      lfsr;
    logic [CNT_W-1:0] cnt;
    logic             fb;

    assign fb        = ^(lfsr & LFSR_TAPS);
    assign pool_full = run && (cnt == CNT_LAST);

    // Shift LFSR output MSB-first into the pool and count fill cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= SEED_EFF;
            pool <= '0;
            cnt  <= '0;
        end else if (run) begin
            lfsr <= {lfsr[30:0], fb};
            pool <= {pool[8*D-2:0], lfsr[31]};
            cnt  <= pool_full ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rambam_encode_feed.sv
// RAMBAM encode feed: encodes plain GF(2^8) bytes as a' = a + P*rho and
// hands them, with the S-box randomness vector, to the downstream stage.
// Optional build macro RAMBAM_ZERO_RAND_EN adds dbg_zero_rand, which forces
// rho and all r groups to zero at accept without disturbing the LFSR sequence.
module rambam_encode_feed
    import rambam_pkg::*;
#(
    parameter int          D         = RAMBAM_D,
    parameter logic [8:0]  P         = DEFAULT_P,
    parameter logic [D:0]  Q         = 5'h13,
    parameter logic [31:0] LFSR_TAPS = DEFAULT_LFSR_TAPS,
    parameter logic [31:0] LFSR_SEED = DEFAULT_LFSR_SEED
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_byte,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [0:7+D]         out_data,
    output logic [0:6][0:D-1]    out_r
`ifdef RAMBAM_ZERO_RAND_EN
    ,
    input  logic                 dbg_zero_rand
`endif
);

    // Q is only carried for consistency with the S-box; reject mismatched sets at elaboration
    if (D != RAMBAM_D || Q[D] != 1'b1) begin : g_param_check
        $error("rambam_encode_feed: D must equal RAMBAM_D and Q must have degree D");
    end

    feed_state_t        state;
    logic [8*D-1:0]     pool;
    logic               pool_full;
    logic               accept;
    logic               zero_rand;
    logic [D-1:0]       rho;
    logic [7+D:0]       enc;
    logic [0:6][0:D-1]  r_next;

`ifdef RAMBAM_ZERO_RAND_EN
    assign zero_rand = dbg_zero_rand;
`else
    assign zero_rand = 1'b0;
`endif

    rambam_lfsr_pool #(
        .D         (D),
        .LFSR_TAPS (LFSR_TAPS),
        .LFSR_SEED (LFSR_SEED)
    ) u_pool (
        .clk       (clk),
        .rst       (rst),
        .run       (state == FILL),
        .pool      (pool),
        .pool_full (pool_full)
    );

    // Ready only depends on state and the output slot, never on in_valid
    assign in_ready = (state == READY) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign rho      = zero_rand ? '0 : pool[D-1:0];
    assign enc      = {{D{1'b0}}, in_byte} ^ clmul_p(P, rho);

    // Slice the upper pool bits into seven D-bit groups, slice MSB at group index 0
    always_comb begin
        r_next = '0;
        for (int i = 0; i < 7; i++) begin
            r_next[i] = zero_rand ? '0 : pool[D*(i+1) +: D];
        end
    end

    // Fill/ready sequencing plus the registered output slot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= FILL;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_r     <= '0;
        end else begin
            if (state == FILL) begin
                if (pool_full) state <= READY;
            end else begin
                if (accept) state <= FILL;
            end
            if (accept) begin
                out_data  <= enc;
                out_r     <= r_next;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rambam_encode_feed.sv
// Directed bench for rambam_encode_feed (D=4, P=0x11B); the LFSR/pool
// behaviour is reproduced by a small reference model of the random stream.
module tb_rambam_encode_feed;
    import rambam_pkg::*;

    localparam int          D    = 4;
    localparam logic [8:0]  P    = 9'h11B;
    localparam logic [31:0] TAPS = 32'h80200003;
    localparam logic [31:0] SEED = 32'hACE12468;

    logic              clk       = 1'b0;
    logic              rst       = 1'b0;
    logic              in_valid  = 1'b0;
    logic              out_ready = 1'b0;
    logic [7:0]        in_byte   = 8'h00;
    logic              in_ready;
    logic              out_valid;
    logic [0:7+D]      out_data;
    logic [0:6][0:D-1] out_r;
`ifdef RAMBAM_ZERO_RAND_EN
    logic              dbg_zero_rand = 1'b0;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_lfsr;
    logic [31:0] m_pool;

    always #5 clk = ~clk;

    rambam_encode_feed dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_byte       (in_byte),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_r         (out_r)
`ifdef RAMBAM_ZERO_RAND_EN
        ,
        .dbg_zero_rand (dbg_zero_rand)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
            $error("%s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // 32 LFSR steps push the whole current state into the pool, MSB first
    function automatic logic [31:0] adv32(input logic [31:0] s);
        logic [31:0] t;
        t = s;
        for (int k = 0; k < 32; k++) t = {t[30:0], ^(t & TAPS)};
        return t;
    endfunction

    task automatic model_fill();
        m_pool = m_lfsr;
        m_lfsr = adv32(m_lfsr);
    endtask

    function automatic logic [11:0] exp_data(input logic [7:0] b, input logic [31:0] pl);
        return {4'b0000, b} ^ clmul_p(P, pl[3:0]);
    endfunction

    function automatic logic [27:0] exp_r(input logic [31:0] pl);
        logic [0:6][0:3] r;
        for (int i = 0; i < 7; i++) r[i] = pl[4*(i+1) +: 4];
        return r;
    endfunction

    function automatic logic [7:0] mod_p(input logic [11:0] v);
        logic [11:0] t;
        t = v;
        for (int k = 11; k >= 8; k--) begin
            if (t[k]) t = t ^ ({3'b000, P} << (k - 8));
        end
        return t[7:0];
    endfunction

    initial begin
        int         n;
        int         first_rdy;
        logic       ok;
        logic [7:0] b;

        // reset held
        repeat (3) tick();
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_r", 32'(out_r), 32'h0);
        chk("clmul_rho3", 32'({4'b0000, 8'h01} ^ clmul_p(P, 4'b0011)), 32'h32C);

        // first fill after release
        rst = 1'b1;
        m_lfsr = SEED;
        n = 0; ok = 1'b1;
        while (!in_ready && n < 40) begin
            tick(); n++;
            if (out_valid !== 1'b0 || out_data !== 12'h000) ok = 1'b0;
        end
        chk("fill_len", 32'(n), 32'd32);
        chk("fill_quiet", 32'(ok), 32'h1);

        // first accept: pool equals seed, rho=8
        model_fill();
        in_byte = 8'h53; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("acc1_valid", 32'(out_valid), 32'h1);
        chk("acc1_data", 32'(out_data), 32'h88B);
        chk("acc1_r", 32'(out_r), 32'h6421ECA);
        chk("acc1_model", 32'(out_data), 32'(exp_data(8'h53, m_pool)));
        chk("acc1_in_ready", 32'(in_ready), 32'h0);

        // backpressure across a full refill
        ok = 1'b1;
        repeat (40) begin
            tick();
            if (out_data !== 12'h88B || out_r !== 28'h6421ECA || out_valid !== 1'b1) ok = 1'b0;
        end
        chk("bp_stable", 32'(ok), 32'h1);
        chk("bp_in_ready", 32'(in_ready), 32'h0);

        // consume and accept together
        model_fill();
        in_byte = 8'h01; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("ca_in_ready_comb", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        chk("ca_valid", 32'(out_valid), 32'h1);
        chk("ca_data", 32'(out_data), 32'(exp_data(8'h01, m_pool)));
        chk("ca_r", 32'(out_r), 32'(exp_r(m_pool)));

        // plain consume
        tick();
        chk("cons_valid", 32'(out_valid), 32'h0);
        chk("cons_hold", 32'(out_data), 32'(exp_data(8'h01, m_pool)));

        // in_valid held during fill
        model_fill();
        in_byte = 8'hA5; in_valid = 1'b1;
        n = 0; first_rdy = -1;
        while (!out_valid && n < 40) begin
            tick(); n++;
            if (in_ready && first_rdy < 0) first_rdy = n;
        end
        in_valid = 1'b0;
        chk("fillv_first_ready", 32'(first_rdy), 32'd31);
        chk("fillv_accept_at", 32'(n), 32'd32);
        chk("fillv_data", 32'(out_data), 32'(exp_data(8'hA5, m_pool)));
        chk("fillv_modp", 32'(mod_p(out_data)), 32'h0A5);

        // random bytes against the stream model
        for (int k = 0; k < 1000; k++) begin
            n = 0;
            while (!in_ready && n < 40) begin tick(); n++; end
            chk("rand_ready", 32'(in_ready), 32'h1);
            if (!in_ready) break;
            model_fill();
            b = 8'($urandom);
            in_byte = b; in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            chk("rand_data", 32'(out_data), 32'(exp_data(b, m_pool)));
            chk("rand_r", 32'(out_r), 32'(exp_r(m_pool)));
            chk("rand_modp", 32'(mod_p(out_data)), 32'(b));
        end

`ifdef RAMBAM_ZERO_RAND_EN
        // forced-zero randomness
        n = 0;
        while (!in_ready && n < 40) begin tick(); n++; end
        chk("zr_ready", 32'(in_ready), 32'h1);
        model_fill();
        dbg_zero_rand = 1'b1; in_byte = 8'h53; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; dbg_zero_rand = 1'b0;
        chk("zr_valid", 32'(out_valid), 32'h1);
        chk("zr_data", 32'(out_data), 32'h053);
        chk("zr_r", 32'(out_r), 32'h0);
`endif

        // reset with a pending output mid-fill
        n = 0;
        while (!in_ready && n < 40) begin tick(); n++; end
        model_fill();
        out_ready = 1'b0; in_byte = 8'h3C; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("mr_valid_before", 32'(out_valid), 32'h1);
        repeat (10) tick();
        #3;
        rst = 1'b0;
        #1;
        chk("mr_out_valid", 32'(out_valid), 32'h0);
        chk("mr_out_data", 32'(out_data), 32'h0);
        chk("mr_out_r", 32'(out_r), 32'h0);
        chk("mr_in_ready", 32'(in_ready), 32'h0);
        repeat (2) tick();
        rst = 1'b1;
        out_ready = 1'b1;
        m_lfsr = SEED;
        n = 0;
        while (!in_ready && n < 40) begin tick(); n++; end
        chk("mr_fill_len", 32'(n), 32'd32);
        model_fill();
        in_byte = 8'h53; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("mr_data", 32'(out_data), 32'h88B);
        chk("mr_r", 32'(out_r), 32'h6421ECA);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
